// File: rtl/noc_packet_sink.sv
// Boundary flit receiver: buffers credit-flow flits and frames them into sop/eop packets.
// Latency: a flit accepted at edge t appears on pkt_data_o with pkt_valid_o after edge t.
// Backpressure: credit_o drops while the FIFO is full; pkt_ready_i low holds the output stable.
module noc_packet_sink #(
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rx_i,
    input  logic [FLIT_SIZE-1:0]   data_i,
    output logic                   credit_o,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic [FLIT_SIZE-1:0]   pkt_data_o,
    output logic                   pkt_sop_o,
    output logic                   pkt_eop_o,
    output logic [15:0]            pkt_target_o,
    output logic [COUNT_WIDTH-1:0] pkt_count_o,
    output logic                   overflow_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam int PW    = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_SIZE    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    // Flit storage; contents are don't-care after reset, so no reset on the array.
    logic [FLIT_SIZE-1:0]   mem_q [BUFFER_DEPTH];

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    state_e                 state_q, state_d;
    logic [FLIT_SIZE-1:0]   remaining_q, remaining_d;
    logic [15:0]            target_q, target_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;

    logic                   full;
    logic                   empty;
    logic                   wr_en;
    logic                   rd_en;
    logic [FLIT_SIZE-1:0]   head_flit;

    // Occupancy flags and the two handshakes that move the pointers.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        wr_en = rx_i && !full;
        rd_en = !empty && pkt_ready_i;
    end

    assign head_flit    = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign credit_o     = !full;
    assign pkt_valid_o  = !empty;
    assign pkt_data_o   = head_flit;
    assign pkt_target_o = target_q;
    assign pkt_count_o  = count_q;
    assign overflow_o   = overflow_q;

    // Pointer advance: each side moves independently on its own handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Flit write into the slot addressed by the write pointer.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

    // Pointer registers; reset empties the FIFO and drops any partial packet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Framing state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing next state: only an output handshake advances the packet position.
    always_comb begin
        state_d = state_q;
        if (rd_en) begin
            case (state_q)
                ST_HEADER: begin
                    state_d = ST_SIZE;
                end
                ST_SIZE: begin
                    if (head_flit == '0) begin
                        state_d = ST_HEADER;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (remaining_q == FLIT_SIZE'(1)) begin
                        state_d = ST_HEADER;
                    end
                end
                default: begin
                    state_d = ST_HEADER;
                end
            endcase
        end
    end

    // Framing outputs: markers follow the state even when no flit is presented.
    always_comb begin
        pkt_sop_o = 1'b0;
        pkt_eop_o = 1'b0;
        case (state_q)
            ST_HEADER: begin
                pkt_sop_o = 1'b1;
            end
            ST_SIZE: begin
                pkt_eop_o = (head_flit == '0);
            end
            ST_PAYLOAD: begin
                pkt_eop_o = (remaining_q == FLIT_SIZE'(1));
            end
            default: begin
                pkt_sop_o = 1'b1;
            end
        endcase
    end

    // Packet bookkeeping: target latch, payload countdown, completion count, overflow.
    always_comb begin
        target_d    = target_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (rx_i & full);
        if (rd_en) begin
            case (state_q)
                ST_HEADER: begin
                    target_d = head_flit[15:0];
                end
                ST_SIZE: begin
                    if (head_flit == '0) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end else begin
                        remaining_d = head_flit;
                    end
                end
                ST_PAYLOAD: begin
                    remaining_d = remaining_q - FLIT_SIZE'(1);
                    if (remaining_q == FLIT_SIZE'(1)) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    remaining_d = '0;
                end
            endcase
        end
    end

    // Bookkeeping registers; overflow is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            target_q    <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            target_q    <= target_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_noc_packet_sink.sv
// Bench for noc_packet_sink: directed scenarios plus randomized packets against a queue model.
// Outputs are sampled 1 time unit after each rising edge.
// The source only drives rx_i while credit_o is high, except in the forced-overflow step.
module tb_noc_packet_sink;

    localparam int FW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          rx_i;
    logic [FW-1:0] data_i;
    logic          credit_o;
    logic          pkt_valid_o;
    logic          pkt_ready_i;
    logic [FW-1:0] pkt_data_o;
    logic          pkt_sop_o;
    logic          pkt_eop_o;
    logic [15:0]   pkt_target_o;
    logic [CW-1:0] pkt_count_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    noc_packet_sink #(
        .FLIT_SIZE   (FW),
        .BUFFER_DEPTH(DEPTH),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_i      (data_i),
        .credit_o    (credit_o),
        .pkt_valid_o (pkt_valid_o),
        .pkt_ready_i (pkt_ready_i),
        .pkt_data_o  (pkt_data_o),
        .pkt_sop_o   (pkt_sop_o),
        .pkt_eop_o   (pkt_eop_o),
        .pkt_target_o(pkt_target_o),
        .pkt_count_o (pkt_count_o),
        .overflow_o  (overflow_o)
    );

    int checks = 0;
    int errors = 0;

    // Source queue (flits waiting to be offered) and the model of buffered flits.
    int unsigned src_q[$];
    int unsigned mq[$];
    // Position of the head flit within its packet: 0 header, 1 size, 2.. payload.
    longint      pos;
    longint      n_sz;
    int unsigned m_count;
    logic [15:0] m_target;
    bit          m_ovf;

    int rdy_mode;   // 0: never ready, 1: always ready, 2: random
    int rx_pct;     // chance the source offers an available flit
    bit force_rx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        src_q.delete();
        mq.delete();
        pos      = 0;
        n_sz     = 0;
        m_count  = 0;
        m_target = 16'h0;
        m_ovf    = 1'b0;
    endtask

    function automatic bit exp_eop();
        if (pos == 1) return (mq[0] == 0);
        if (pos >= 2) return (pos == n_sz + 1);
        return 1'b0;
    endfunction

    task automatic compare_all();
        chk("valid", {31'd0, pkt_valid_o}, {31'd0, mq.size() > 0});
        chk("credit", {31'd0, credit_o}, {31'd0, mq.size() < DEPTH});
        chk("sop", {31'd0, pkt_sop_o}, {31'd0, pos == 0});
        if (mq.size() > 0) begin
            chk("data", pkt_data_o, mq[0]);
            chk("eop", {31'd0, pkt_eop_o}, {31'd0, exp_eop()});
        end
        chk("count", {28'd0, pkt_count_o}, m_count);
        chk("target", {16'd0, pkt_target_o}, {16'd0, m_target});
        chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
    endtask

    // One clock: drive inputs, advance the model, clock, then compare.
    task automatic cycle();
        bit          acc;
        bit          hs;
        int unsigned hd;
        rx_i   = 1'b0;
        data_i = $urandom;
        if (force_rx) begin
            rx_i = 1'b1;
        end else if (src_q.size() > 0 && credit_o && ($urandom_range(99) < rx_pct)) begin
            rx_i   = 1'b1;
            data_i = src_q[0];
        end
        case (rdy_mode)
            0:       pkt_ready_i = 1'b0;
            1:       pkt_ready_i = 1'b1;
            default: pkt_ready_i = 1'($urandom_range(1));
        endcase
        acc = rx_i && (mq.size() < DEPTH);
        if (rx_i && mq.size() >= DEPTH) m_ovf = 1'b1;
        hs = pkt_ready_i && (mq.size() > 0);
        if (hs) begin
            hd = mq.pop_front();
            if (pos == 0) begin
                m_target = hd[15:0];
                pos      = 1;
            end else if (pos == 1) begin
                n_sz = longint'(hd);
                if (hd == 0) begin
                    m_count = (m_count + 1) % (1 << CW);
                    pos     = 0;
                end else begin
                    pos = 2;
                end
            end else if (pos == n_sz + 1) begin
                m_count = (m_count + 1) % (1 << CW);
                pos     = 0;
            end else begin
                pos = pos + 1;
            end
        end
        if (acc) begin
            mq.push_back(data_i);
            if (!force_rx) void'(src_q.pop_front());
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_idle(input int max_cycles);
        int n = 0;
        while ((src_q.size() > 0 || mq.size() > 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("drain_timeout", src_q.size() + mq.size(), 0);
    endtask

    task automatic add_pkt(input int unsigned hdr, input int unsigned sz);
        src_q.push_back(hdr);
        src_q.push_back(sz);
        for (int i = 0; i < int'(sz); i++) src_q.push_back($urandom);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        rx_i        = 1'b0;
        pkt_ready_i = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        chk("rst_credit", {31'd0, credit_o}, 32'd1);
        chk("rst_sop", {31'd0, pkt_sop_o}, 32'd1);
        chk("rst_eop", {31'd0, pkt_eop_o}, 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        rx_i        = 1'b0;
        data_i      = '0;
        pkt_ready_i = 1'b0;
        force_rx    = 1'b0;
        rx_pct      = 100;
        rdy_mode    = 1;
        model_reset();
        do_reset();

        // Single packet, no backpressure.
        src_q.push_back(32'h0102);
        src_q.push_back(32'd2);
        src_q.push_back(32'hA);
        src_q.push_back(32'hB);
        run_idle(20);
        chk("single_target", {16'd0, pkt_target_o}, 32'h0102);
        chk("single_count", {28'd0, pkt_count_o}, 32'd1);

        // Zero-size packet followed by a one-flit payload packet.
        add_pkt(32'h0003, 0);
        add_pkt(32'h0005, 1);
        run_idle(20);
        chk("zero_count", {28'd0, pkt_count_o}, 32'd3);
        chk("zero_target", {16'd0, pkt_target_o}, 32'h0005);

        // Fill with no consumer: source stalls on credit, no overflow.
        rdy_mode = 0;
        add_pkt(32'h0010, 8);
        for (int i = 0; i < 12; i++) cycle();
        chk("fill_credit", {31'd0, credit_o}, 32'd0);
        chk("fill_src_left", src_q.size(), 32'd2);
        chk("fill_no_ovf", {31'd0, overflow_o}, 32'd0);
        rdy_mode = 1;
        run_idle(40);
        chk("fill_count", {28'd0, pkt_count_o}, 32'd4);

        // Forced write while full: flit dropped, overflow sticky.
        rdy_mode = 0;
        add_pkt(32'h0020, 6);
        add_pkt(32'h0021, 0);
        for (int i = 0; i < 10; i++) cycle();
        force_rx = 1'b1;
        cycle();
        force_rx = 1'b0;
        chk("ovf_set", {31'd0, overflow_o}, 32'd1);
        for (int i = 0; i < 3; i++) cycle();
        rdy_mode = 1;
        run_idle(40);
        chk("ovf_sticky", {31'd0, overflow_o}, 32'd1);
        chk("ovf_count", {28'd0, pkt_count_o}, 32'd6);

        // Reset after header, size and first of three payload flits.
        add_pkt(32'h0030, 3);
        for (int i = 0; i < 4; i++) cycle();
        do_reset();
        chk("midrst_target", {16'd0, pkt_target_o}, 32'd0);
        chk("midrst_count", {28'd0, pkt_count_o}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow_o}, 32'd0);
        add_pkt(32'h0040, 1);
        run_idle(20);
        chk("postrst_target", {16'd0, pkt_target_o}, 32'h0040);
        chk("postrst_count", {28'd0, pkt_count_o}, 32'd1);

        // Randomized packets and stalls; 17 packets wrap the 4-bit counter to 1.
        do_reset();
        rdy_mode = 2;
        rx_pct   = 70;
        for (int k = 0; k < 17; k++) add_pkt($urandom_range(16'hFFFF), $urandom_range(5));
        run_idle(3000);
        chk("wrap_count", {28'd0, pkt_count_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
